// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter that time-shares one external ALU between NUM_REQ requesters.
// Latency: request accepted in cycle t, response valid from cycle t+2; one transaction in flight.
// Backpressure: no grant while busy; response held stable until the owner's i_rsp_ready.

package alu_share_pkg;
    typedef enum logic [3:0] {
        OP_ALU_ADD  = 4'd0,
        OP_ALU_SUB  = 4'd1,
        OP_ALU_AND  = 4'd2,
        OP_ALU_OR   = 4'd3,
        OP_ALU_XOR  = 4'd4,
        OP_ALU_SLL  = 4'd5,
        OP_ALU_SRL  = 4'd6,
        OP_ALU_SRA  = 4'd7,
        OP_ALU_SLT  = 4'd8,
        OP_ALU_SLTU = 4'd9,
        OP_ALU_PC   = 4'd10
    } alu_op_t;
endpackage

module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  alu_op_t [NUM_REQ-1:0]    i_req_op,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    input  logic [NUM_REQ-1:0]       i_rsp_ready,
    output logic [WIDTH-1:0]         o_rsp_result,
    output logic [IDW-1:0]           o_rsp_id,
    output alu_op_t                  o_alu_op,
    output logic [WIDTH-1:0]         o_alu_a,
    output logic [WIDTH-1:0]         o_alu_b,
    input  logic [WIDTH-1:0]         i_alu_result,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;

    // Round-robin search from rr_ptr; scanning offsets high to low lets the nearest valid win.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            // (rr_ptr + i) mod NUM_REQ without needing a carry bit
            if (32'(rr_ptr_q) >= 32'(NUM_REQ - i)) begin
                cand = rr_ptr_q - IDW'(NUM_REQ - i);
            end else begin
                cand = rr_ptr_q + IDW'(i);
            end
            if (i_req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Next-state logic, operand capture and handshake outputs.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        o_req_ready = '0;
        o_rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    o_req_ready[gnt_idx] = 1'b1;
                    owner_d              = gnt_idx;
                    op_d                 = i_req_op[gnt_idx];
                    a_d                  = i_req_a[gnt_idx*WIDTH +: WIDTH];
                    b_d                  = i_req_b[gnt_idx*WIDTH +: WIDTH];
                    state_d              = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = i_alu_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid[owner_q] = 1'b1;
                if (i_rsp_ready[owner_q]) begin
                    // pointer moves past the requester just served
                    rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= OP_ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign o_alu_op     = op_q;
    assign o_alu_a      = a_q;
    assign o_alu_b      = b_q;
    assign o_rsp_result = result_q;
    assign o_rsp_id     = owner_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with three requesters; the bench also plays the ALU.
// Latency: directed scenarios step cycle by cycle; random phase runs a transaction-level model.
// Backpressure: response ready is driven per scenario and randomly in the random phase.

module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int W = 32;
    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    alu_op_t [N-1:0] req_op;
    logic [N*W-1:0]  req_a, req_b;
    logic [W-1:0]    rsp_result, alu_a, alu_b, alu_result;
    logic [1:0]      rsp_id;
    alu_op_t         alu_op;
    logic            busy;

    int errors = 0;
    int checks = 0;

    alu_share_ctrl #(.WIDTH(W), .NUM_REQ(N), .IDW(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_id     (rsp_id),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: plain arithmetic per opcode, unknown opcodes give 0.
    function automatic logic [W-1:0] alu_ref(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ALU_ADD:  return a + b;
            OP_ALU_SUB:  return a - b;
            OP_ALU_AND:  return a & b;
            OP_ALU_OR:   return a | b;
            OP_ALU_XOR:  return a ^ b;
            OP_ALU_SLL:  return a << b[4:0];
            OP_ALU_SRL:  return a >> b[4:0];
            OP_ALU_SRA:  return W'($signed(a) >>> b[4:0]);
            OP_ALU_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            OP_ALU_SLTU: return (a < b) ? 1 : 0;
            OP_ALU_PC:   return a + 4;
            default:     return '0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b);

    // First valid requester searching ptr, ptr+1, ... mod N; -1 when none.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[k]          = op;
        req_a[k*W +: W]    = a;
        req_b[k*W +: W]    = b;
        req_valid[k]       = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_op    = {N{OP_ALU_ADD}};
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_req_ready got=%b exp=000", req_ready); end
        checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (alu_op !== OP_ALU_ADD) begin errors++; $display("FAIL rst_alu_op got=%0d exp=%0d", alu_op, OP_ALU_ADD); end
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL rst_alu_ab got=%h/%h exp=0/0", alu_a, alu_b); end
        checks++; if (rsp_result !== 32'h0 || rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp got=%h id=%0d exp=0 id=0", rsp_result, rsp_id); end
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 3'b111;
        set_req(0, OP_ALU_ADD, 32'd7, 32'd5);
        #2;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", req_ready); end
        step();
        req_valid = '0;
        #2;
        checks++; if (busy !== 1'b1 || rsp_valid !== 3'b000) begin errors++; $display("FAIL single_exec got busy=%b rv=%b exp busy=1 rv=000", busy, rsp_valid); end
        checks++; if (alu_op !== OP_ALU_ADD || alu_a !== 32'd7 || alu_b !== 32'd5) begin errors++; $display("FAIL single_alu_in got=%0d %h %h exp=0 7 5", alu_op, alu_a, alu_b); end
        step();
        #2;
        checks++; if (rsp_valid !== 3'b001 || rsp_result !== 32'd12 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp got rv=%b res=%h id=%0d exp rv=001 res=c id=0", rsp_valid, rsp_result, rsp_id); end
        step();
        #2;
        checks++; if (busy !== 1'b0 || rsp_valid !== 3'b000) begin errors++; $display("FAIL single_idle got busy=%b rv=%b exp 0 000", busy, rsp_valid); end
    endtask

    task automatic test_contention();
        int g;
        logic [W-1:0] exp_res;
        do_reset();
        rsp_ready = 3'b111;
        set_req(0, OP_ALU_SUB, 32'd10, 32'd3);
        set_req(1, OP_ALU_XOR, 32'hF0, 32'h0F);
        for (int t = 0; t < 4; t++) begin
            g       = t % 2;
            exp_res = (g == 1) ? 32'hFF : 32'd7;
            #2;
            checks++; if (req_ready !== 3'(1 << g)) begin errors++; $display("FAIL cont_grant%0d got=%b exp=%b", t, req_ready, 3'(1 << g)); end
            step();
            step();
            #2;
            checks++; if (rsp_valid !== 3'(1 << g) || rsp_result !== exp_res || rsp_id !== 2'(g)) begin
                errors++; $display("FAIL cont_rsp%0d got rv=%b res=%h id=%0d exp rv=%b res=%h id=%0d", t, rsp_valid, rsp_result, rsp_id, 3'(1 << g), exp_res, g);
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 3'b000;
        set_req(0, OP_ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        set_req(1, OP_ALU_ADD, 32'd2, 32'd3);
        #2;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_grant got=%b exp=001", req_ready); end
        step();
        req_valid[0] = 1'b0;
        rsp_ready    = 3'b110;
        #2;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_exec_ready got=%b exp=000", req_ready); end
        for (int c = 0; c < 5; c++) begin
            step();
            #2;
            checks++; if (rsp_valid !== 3'b001 || rsp_result !== 32'd1 || req_ready !== 3'b000) begin
                errors++; $display("FAIL bp_hold%0d got rv=%b res=%h rdy=%b exp rv=001 res=1 rdy=000", c, rsp_valid, rsp_result, req_ready);
            end
        end
        rsp_ready = 3'b001;
        step();
        #2;
        checks++; if (req_ready !== 3'b010 || busy !== 1'b0) begin errors++; $display("FAIL bp_next_grant got rdy=%b busy=%b exp 010 0", req_ready, busy); end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        alu_op_t      ops [5];
        logic [W-1:0] as  [5];
        logic [W-1:0] bs  [5];
        logic [W-1:0] exp [5];
        ops[0] = OP_ALU_ADD;            as[0] = 32'hFFFF_FFFF; bs[0] = 32'd1;  exp[0] = 32'h0;
        ops[1] = OP_ALU_SRA;            as[1] = 32'h8000_0000; bs[1] = 32'd31; exp[1] = 32'hFFFF_FFFF;
        ops[2] = OP_ALU_PC;             as[2] = 32'd100;       bs[2] = 32'd77; exp[2] = 32'd104;
        ops[3] = alu_op_t'(4'd13);      as[3] = 32'd5;         bs[3] = 32'd6;  exp[3] = 32'h0;
        ops[4] = OP_ALU_SLTU;           as[4] = 32'hFFFF_FFFF; bs[4] = 32'd1;  exp[4] = 32'h0;
        for (int e = 0; e < 5; e++) begin
            do_reset();
            rsp_ready = 3'b001;
            set_req(0, ops[e], as[e], bs[e]);
            step();
            req_valid = '0;
            step();
            #2;
            checks++; if (rsp_valid !== 3'b001 || rsp_result !== exp[e]) begin
                errors++; $display("FAIL wrap%0d got rv=%b res=%h exp rv=001 res=%h", e, rsp_valid, rsp_result, exp[e]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rsp_ready = 3'b111;
        set_req(0, OP_ALU_OR, 32'h1, 32'h2);
        step();
        req_valid = '0;
        step();
        step();
        rsp_ready = 3'b000;
        set_req(1, OP_ALU_ADD, 32'd1, 32'd2);
        #2;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL mrst_grant1 got=%b exp=010", req_ready); end
        step();
        req_valid = '0;
        step();
        #2;
        checks++; if (rsp_valid !== 3'b010) begin errors++; $display("FAIL mrst_in_resp got=%b exp=010", rsp_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        checks++; if (rsp_valid !== 3'b000 || busy !== 1'b0 || alu_op !== OP_ALU_ADD) begin
            errors++; $display("FAIL mrst_outputs got rv=%b busy=%b op=%0d exp 000 0 0", rsp_valid, busy, alu_op);
        end
        checks++; if (alu_a !== 32'h0 || rsp_result !== 32'h0 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL mrst_data got a=%h res=%h id=%0d exp 0 0 0", alu_a, rsp_result, rsp_id);
        end
        rsp_ready = 3'b111;
        set_req(0, OP_ALU_ADD, 32'd9, 32'd9);
        set_req(1, OP_ALU_ADD, 32'd1, 32'd2);
        #2;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL mrst_ptr_zero got=%b exp=001", req_ready); end
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        #2;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL mrst_req1_grant got=%b exp=010", req_ready); end
        step();
        req_valid = '0;
        step();
        #2;
        checks++; if (rsp_valid !== 3'b010 || rsp_result !== 32'd3 || rsp_id !== 2'd1) begin
            errors++; $display("FAIL mrst_req1_rsp got rv=%b res=%h id=%0d exp 010 3 1", rsp_valid, rsp_result, rsp_id);
        end
        step();
    endtask

    task automatic test_req2_only();
        do_reset();
        rsp_ready = 3'b111;
        set_req(2, OP_ALU_AND, 32'hF0F0, 32'hFF00);
        #2;
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL r2_grant got=%b exp=100", req_ready); end
        step();
        req_valid = '0;
        step();
        #2;
        checks++; if (rsp_valid !== 3'b100 || rsp_id !== 2'd2 || rsp_result !== 32'hF000) begin
            errors++; $display("FAIL r2_rsp got rv=%b id=%0d res=%h exp 100 2 f000", rsp_valid, rsp_id, rsp_result);
        end
        step();
        set_req(0, OP_ALU_ADD, 32'd1, 32'd1);
        set_req(1, OP_ALU_ADD, 32'd1, 32'd1);
        set_req(2, OP_ALU_ADD, 32'd1, 32'd1);
        #2;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL r2_ptr_wrap got=%b exp=001", req_ready); end
        req_valid = '0;
    endtask

    // Random requesters and response backpressure against a transaction-level model.
    task automatic test_random();
        int           ptr     = 0;
        bit           pending = 1'b0;
        int           age     = 0;
        int           owner   = 0;
        int           acc     = -1;
        int           g;
        logic [W-1:0] exp_res = '0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (acc >= 0) begin
                req_valid[acc] = 1'b0;
                acc = -1;
            end
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    set_req(k, alu_op_t'($urandom_range(0, 12)), rand_operand(), rand_operand());
                end else if (req_valid[k] && $urandom_range(0, 15) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            rsp_ready = 3'($urandom);
            #2;
            if (pending) begin
                age++;
                checks++; if (req_ready !== 3'b000 || busy !== 1'b1) begin
                    errors++; $display("FAIL rnd_busy cyc=%0d got rdy=%b busy=%b exp 000 1", cyc, req_ready, busy);
                end
                if (age == 1) begin
                    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL rnd_early_rsp cyc=%0d got=%b exp=000", cyc, rsp_valid); end
                end else begin
                    checks++; if (rsp_valid !== 3'(1 << owner) || rsp_result !== exp_res || rsp_id !== 2'(owner)) begin
                        errors++; $display("FAIL rnd_rsp cyc=%0d got rv=%b res=%h id=%0d exp rv=%b res=%h id=%0d", cyc, rsp_valid, rsp_result, rsp_id, 3'(1 << owner), exp_res, owner);
                    end
                    if (rsp_ready[owner]) begin
                        ptr     = (owner + 1) % N;
                        pending = 1'b0;
                    end
                end
            end else begin
                g = pick(req_valid, ptr);
                checks++; if (req_ready !== ((g < 0) ? 3'b000 : 3'(1 << g)) || busy !== 1'b0 || rsp_valid !== 3'b000) begin
                    errors++; $display("FAIL rnd_grant cyc=%0d got rdy=%b busy=%b rv=%b exp grant=%0d", cyc, req_ready, busy, rsp_valid, g);
                end
                if (g >= 0) begin
                    owner   = g;
                    exp_res = alu_ref(req_op[g], req_a[g*W +: W], req_b[g*W +: W]);
                    pending = 1'b1;
                    age     = 0;
                    acc     = g;
                end
            end
            step();
        end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_op    = {N{OP_ALU_ADD}};
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_req2_only();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that time-shares one `alu` instance between NUM_REQ requesters, e.g. two issue slots or an execute stage plus an address-generation unit.
- Each requester presents an `alu_op_t` opcode and two operands with a valid/ready handshake.
- The controller drives the external ALU ports and registers the ALU result. It returns the result to the granted requester over a valid/ready response channel.
- One transaction is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; must match the attached `alu`.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- IDW, $clog2(NUM_REQ), width of the requester index.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  per-requester request accept; at most one bit high (one-hot or zero).
- i_req_op  input  NUM_REQ x alu_op_t  packed array, requester k at slice k.
- i_req_a  input  NUM_REQ*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH].
- i_req_b  input  NUM_REQ*WIDTH  operand B, same packing.
- o_rsp_valid  output  NUM_REQ  per-requester response valid; at most one bit high.
- i_rsp_ready  input  NUM_REQ  per-requester response accept.
- o_rsp_result  output  WIDTH  result, shared by all requesters; qualified by o_rsp_valid.
- o_rsp_id  output  IDW  index of the requester that owns the current response.
- o_alu_op  output  alu_op_t  to the ALU `i_alu_op`.
- o_alu_a  output  WIDTH  to the ALU `i_a`.
- o_alu_b  output  WIDTH  to the ALU `i_b`.
- i_alu_result  input  WIDTH  from the ALU `o_result`; combinational.
- o_busy  output  1  high in EXEC and RESP.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset value is IDLE.
- Reset values:
  - rr_ptr = 0.
  - op register = OP_ALU_ADD; operand registers = 0.
  - result register = 0, owner register = 0.
  - All o_req_ready = 0 and all o_rsp_valid = 0; o_busy = 0.
- IDLE:
  - Grant g is the first k with i_req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - o_req_ready[g] is asserted combinationally in the same cycle; all other ready bits are 0.
  - On that edge, capture i_req_op[g], i_req_a[g], i_req_b[g] and owner=g, then move to EXEC.
  - With no valid request, stay in IDLE and keep all ready bits at 0.
- EXEC:
  - o_alu_op/o_alu_a/o_alu_b are driven from the capture registers; these outputs are registered in all states.
  - At the end of the cycle, latch i_alu_result into the result register and move to RESP.
- RESP:
  - o_rsp_valid[owner] = 1, o_rsp_result = result register, o_rsp_id = owner.
  - Hold until i_rsp_ready[owner] = 1. On that edge: rr_ptr = (owner+1) mod NUM_REQ, then move to IDLE.
  - i_rsp_ready bits of other requesters are ignored.
  - Response data stays stable while waiting.
- Latency: request accepted in cycle t (valid and ready both high), response valid from cycle t+2. Best-case throughput is one transaction every 3 cycles.
- Fairness: rr_ptr advances only on response completion. A requester that holds valid is served within NUM_REQ transactions.
- No new grant while o_busy = 1. A requester may change or drop its valid while not granted; no data is captured without ready.
- Result value equals the ALU function of the captured op and operands. Unknown opcodes return 0, because the ALU defines that.
- OP_ALU_PC returns A+4; operand B is ignored.
- Reset asserted mid-transaction (EXEC or RESP) drops the transaction:
  - no response is issued;
  - next cycle all outputs are at reset values;
  - the first post-reset grant starts the search at requester 0.
- All arithmetic wraps modulo 2^WIDTH; this is delegated to the ALU. rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Single request: req0 issues OP_ALU_ADD, a=7, b=5, rsp_ready held at 1.
  -> ready0 in cycle 0; rsp_valid0 in cycle 2 with result 12 and id 0; back in IDLE in cycle 3.
- Contention: req0 and req1 both valid continuously, rr_ptr=0; req0 does SUB 10-3, req1 does XOR 0xF0^0x0F.
  -> grants alternate 0,1,0,1; results 7 and 0xFF; no requester is granted twice in a row.
- Response backpressure: rsp_ready0 held at 0 for 5 cycles on SLT a=0xFFFFFFFF, b=1.
  -> rsp_valid0 held stable with result 1 for all 5 cycles; req1 valid meanwhile gets ready1=0 until the response completes.
- Wrap-around: OP_ALU_ADD with a=0xFFFFFFFF, b=1 -> result 0. SRA with a=0x80000000, b=31 -> result 0xFFFFFFFF.
- Reset mid-operation: assert i_rst in the RESP state.
  -> next cycle rsp_valid=0, busy=0, alu_op=OP_ALU_ADD; a following request from req1 is accepted and answered normally.
- NUM_REQ=3, only req2 valid, rr_ptr=0 -> req2 granted in the first IDLE cycle; rr_ptr becomes 0 after its response completes.
